// File: rtl/lsu_mem_bridge_pkg.sv
// Shared definitions for the load/store memory bridge: access-size and
// FSM state encodings, the per-request context record and the stall LFSR taps.
package lsu_mem_bridge_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    // Bridge control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RSP     = 2'd2
    } state_e;

    // Fibonacci LFSR taps 16,14,13,11 expressed as a mask on bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Context captured when a request is accepted.
    typedef struct packed {
        logic [1:0] off;
        size_e      size;
        logic       uns;
        logic       we;
        logic       err;
    } req_info_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the bridge: store strobes with lane
// replication, and load byte extraction with sign/zero extension.
module lsu_align
    import lsu_mem_bridge_pkg::*;
(
    input  size_e       st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_strb_o,
    input  size_e       ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;

    // Store path: replicate the low bytes into every lane and pick the strobe.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        st_data_o = st_data_i;
        st_strb_o = 4'hF;
        case (st_size_i)
            SZ_BYTE: begin
                st_data_o = {4{st_data_i[7:0]}};
                st_strb_o = 4'b0001 << st_off_i;
            end
            SZ_HALF: begin
                st_data_o = {2{st_data_i[15:0]}};
                st_strb_o = 4'b0011 << st_off_i;
            end
            default: ;
        endcase
    end

    assign ld_shifted = ld_data_i >> {ld_off_i, 3'b000};

    // Load path: take the addressed bytes from lane 0 and extend to 32 bits.
    always_comb begin
        ld_data_o = ld_shifted;
        case (ld_size_i)
            SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'h0, ld_shifted[7:0]}
                                               : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_HALF: ld_data_o = ld_unsigned_i ? {16'h0, ld_shifted[15:0]}
                                               : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge in front of the two-port memory. One request in flight;
// stores and errors answer one cycle after accept, loads two cycles after.
// Optional build macro LSU_BRIDGE_STALL_EN adds LFSR-driven random
// back-pressure on req_ready.
module lsu_mem_bridge
    import lsu_mem_bridge_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 4096
`ifdef LSU_BRIDGE_STALL_EN
    , parameter logic [15:0] STALL_SEED = 16'hACE1
`endif
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rready,
    output logic        mem_wready,
    output logic [29:0] mem_raddr,
    output logic [29:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    req_info_t   info_q, info_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] ld_data;
    logic        stall_ok;
    logic        accept;
    logic        req_err;

`ifdef LSU_BRIDGE_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    assign stall_ok = (lfsr_q[1:0] != 2'b00);

    // Free-running stall LFSR.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) lfsr_q <= STALL_SEED;
        else         lfsr_q <= lfsr_d;
    end
`else
    assign stall_ok = 1'b1;
`endif

    assign req_ready = resetb && stall_ok &&
                       ((state_q == IDLE) || ((state_q == RSP) && rsp_ready));
    assign accept    = req_valid && req_ready;

    assign req_err = (req_size == SZ_ILL) ||
                     ((req_size == SZ_HALF) && req_addr[0]) ||
                     ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                     (req_addr >= MEM_SIZE);

    assign mem_raddr  = req_addr[31:2];
    assign mem_waddr  = req_addr[31:2];
    assign mem_rready = accept && !req_we && !req_err;
    assign mem_wready = accept &&  req_we && !req_err;

    lsu_align u_align (
        .st_size_i     (size_e'(req_size)),
        .st_off_i      (req_addr[1:0]),
        .st_data_i     (req_wdata),
        .st_data_o     (mem_wdata),
        .st_strb_o     (mem_wstrb),
        .ld_size_i     (info_q.size),
        .ld_off_i      (info_q.off),
        .ld_unsigned_i (info_q.uns),
        .ld_data_i     (mem_rdata),
        .ld_data_o     (ld_data)
    );

    assign rsp_valid = (state_q == RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = info_q.err;

    // Next-state logic: accept from IDLE or RSP, capture load data in RD_DATA.
    always_comb begin
        state_d     = state_q;
        info_d      = info_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE, RSP: begin
                if (accept) begin
                    info_d = '{off:  req_addr[1:0],
                               size: size_e'(req_size),
                               uns:  req_unsigned,
                               we:   req_we,
                               err:  req_err};
                    rsp_rdata_d = '0;
                    state_d     = (!req_we && !req_err) ? RD_DATA : RSP;
                end else if (state_q == RSP && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                rsp_rdata_d = info_q.we ? '0 : ld_data;
                state_d     = RSP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            info_q      <= '0;
            rsp_rdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            info_q      <= info_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Scoreboard bench for lsu_mem_bridge with a behavioural two-port memory.
module tb_lsu_mem_bridge;

    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, X = 2'd3;

    logic        clk, resetb;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rready, mem_wready;
    logic [29:0] mem_raddr, mem_waddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          head_seen = 0;
    int          w;
    logic [31:0] mem_q [1024];
    logic [31:0] rnd [16];

    lsu_mem_bridge dut (
        .clk(clk), .resetb(resetb),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rready(mem_rready), .mem_wready(mem_wready),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 1024; i++) mem_q[i] = '0;
        mem_rdata = '0;
    end

    // Two-port memory: strobed write, read data one cycle after mem_rready.
    always @(posedge clk) begin
        if (mem_wready)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem_q[mem_waddr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (mem_rready) mem_rdata <= mem_q[mem_raddr[9:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on first presentation, data and error on handshake.
    always @(negedge clk) begin
        if (!resetb) begin
            head_seen = 0;
        end else if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_spurious", 32'd1, 32'd0);
            end else begin
                if (!head_seen) begin
                    check("rsp_latency", 32'(cyc - sb_q[0].acc_cyc), 32'(sb_q[0].lat));
                    head_seen = 1;
                end
                if (rsp_ready) begin
                    check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, sb_q[0].err});
                    void'(sb_q.pop_front());
                    head_seen = 0;
                end
            end
        end
    end

    // Drive one request (entered at posedge+1), wait for acceptance, check the
    // memory-side outputs in the accept cycle and queue the expected response.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                         output int waits);
        bit   got = 0;
        exp_t e;
        waits        = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!got && waits < 50) begin
            @(negedge clk);
            if (req_ready) got = 1;
            else begin
                @(posedge clk); #1;
                waits++;
            end
        end
        if (!got) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            check("mem_raddr", {2'b0, mem_raddr}, {2'b0, addr[31:2]});
            check("mem_rready", {31'b0, mem_rready}, {31'b0, !we && !exp_err});
            check("mem_wready", {31'b0, mem_wready}, {31'b0, we && !exp_err});
            if (we && !exp_err) begin
                check("mem_waddr", {2'b0, mem_waddr}, {2'b0, addr[31:2]});
                check("mem_wdata", mem_wdata, exp_wdata);
                check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_strb});
            end
            e.rdata   = exp_rdata;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            e.lat     = (we || exp_err) ? 1 : 2;
            sb_q.push_back(e);
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_wdata, input logic [3:0] exp_strb, output int waits);
        issue(1'b1, size, 1'b0, addr, wdata, 32'h0, 1'b0, exp_wdata, exp_strb, waits);
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] exp_rdata);
        int waits;
        issue(1'b0, size, uns, addr, 32'h0, exp_rdata, 1'b0, 32'h0, 4'h0, waits);
    endtask

    task automatic bad(input logic we, input logic [1:0] size, input logic [31:0] addr);
        int waits;
        issue(we, size, 1'b0, addr, 32'hDEAD_BEEF, 32'h0, 1'b1, 32'h0, 4'h0, waits);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_req_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        resetb = 1'b1;
        @(posedge clk); #1;

        // Sub-word stores
        st(B, 32'h103, 32'h0000_005A, 32'h5A5A_5A5A, 4'b1000, w);
        st(W, 32'h200, 32'h80F0_1234, 32'h80F0_1234, 4'b1111, w);
        st(H, 32'h302, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, w);

        // Loads with extension
        ld(H, 1'b0, 32'h202, 32'hFFFF_80F0);
        ld(H, 1'b1, 32'h202, 32'h0000_80F0);
        ld(B, 1'b0, 32'h201, 32'h0000_0012);
        ld(B, 1'b0, 32'h203, 32'hFFFF_FF80);
        ld(B, 1'b1, 32'h203, 32'h0000_0080);
        ld(B, 1'b0, 32'h103, 32'h0000_005A);
        ld(W, 1'b0, 32'h200, 32'h80F0_1234);
        ld(H, 1'b1, 32'h302, 32'h0000_BEEF);
        ld(W, 1'b0, 32'h300, 32'hBEEF_0000);
        ld(W, 1'b0, 32'h100, 32'h5A00_0000);

        // Error cases: no memory access, err at T+1
        bad(1'b0, W, 32'h006);
        bad(1'b0, X, 32'h000);
        bad(1'b0, W, 32'h1000);
        bad(1'b1, H, 32'h101);
        bad(1'b1, B, 32'hFFFF_FFFF);
        bad(1'b0, B, 32'h0FFF + 32'h1);

        // Back-to-back stores at full rate, then read-after-write
        st(W, 32'h010, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 4'b1111, w);
        st(H, 32'h016, 32'h0000_7788, 32'h7788_7788, 4'b1100, w);
`ifndef LSU_BRIDGE_STALL_EN
        check("b2b_store_wait", 32'(w), 32'd0);
`endif
        st(B, 32'h015, 32'h0000_0099, 32'h9999_9999, 4'b0010, w);
`ifndef LSU_BRIDGE_STALL_EN
        check("b2b_store_wait", 32'(w), 32'd0);
`endif
        st(B, 32'h014, 32'h0000_0001, 32'h0101_0101, 4'b0001, w);
`ifndef LSU_BRIDGE_STALL_EN
        check("b2b_store_wait", 32'(w), 32'd0);
`endif
        ld(W, 1'b0, 32'h014, 32'h7788_9901);
        ld(H, 1'b0, 32'h010, 32'hFFFF_C3D4);
        ld(B, 1'b1, 32'h013, 32'h0000_00A1);
        drain();

        // Response back-pressure: hold for 5 cycles, then same-cycle accept
        rsp_ready = 1'b0;
        ld(W, 1'b0, 32'h200, 32'h80F0_1234);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'h80F0_1234);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        st(W, 32'h040, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, w);
`ifndef LSU_BRIDGE_STALL_EN
        check("release_same_cycle_accept", 32'(w), 32'd0);
`endif
        ld(W, 1'b0, 32'h040, 32'hCAFE_F00D);
        drain();

        // Reset while in RD_DATA: pending load response is dropped
        req_valid = 1'b1; req_we = 1'b0; req_size = W; req_unsigned = 1'b0;
        req_addr = 32'h200;
        begin
            int n = 0;
            @(negedge clk);
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("rst_test_accept", {31'b0, req_ready}, 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resetb = 1'b0;
        #1;
        check("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("midrst_rsp_valid_hold", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        resetb = 1'b1;
        @(posedge clk); #1;
        ld(W, 1'b0, 32'h300, 32'hBEEF_0000);
        ld(H, 1'b0, 32'h016, 32'h0000_7788);
        drain();

        // Random word data: stores then loads
        for (int i = 0; i < 16; i++) begin
            rnd[i] = $urandom;
            st(W, 32'h800 + 32'(4 * i), rnd[i], rnd[i], 4'b1111, w);
        end
        for (int i = 0; i < 16; i++) ld(W, 1'b0, 32'h800 + 32'(4 * i), rnd[i]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
